// File: rtl/fifo_pop_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pop_pkg
//
// Shared definitions for the FIFO read-side controller (fifo_pop_ctrl) and
// its skid buffer (pop_skid_buf).
//
// Contents:
//   ST_IDLE / ST_RUN / ST_FLUSH : state encodings of the enable/flush FSM
//   state_t                     : enumerated FSM state type using those codes
//   SKID_DEPTH_DEF              : default number of skid buffer entries
//   occ_width()                 : width needed to hold an occupancy 0..depth
// -----------------------------------------------------------------------------
package fifo_pop_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        RUN   = ST_RUN,
        FLUSH = ST_FLUSH
    } state_t;

    // Two entries are enough to cover the FIFO's one-cycle read latency while
    // still sustaining one word per cycle.
    localparam int SKID_DEPTH_DEF = 2;

    // Occupancy counts from 0 up to and including depth, hence depth + 1 codes.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_pop_ctrl_if.sv
// -----------------------------------------------------------------------------
// fifo_pop_ctrl_if
//
// Downstream valid/ready word stream leaving the FIFO read-side controller.
//
// Signals:
//   out_valid  producer -> consumer  out_data holds a word
//   out_ready  consumer -> producer  consumer accepts when high with out_valid
//   out_data   producer -> consumer  BW-bit word
//
// Modports:
//   master : the controller driving the stream
//   slave  : the consumer of the stream
// -----------------------------------------------------------------------------
interface fifo_pop_ctrl_if #(
    parameter int BW = 4
);

    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] out_data;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );

endinterface

// File: rtl/pop_skid_buf.sv
// -----------------------------------------------------------------------------
// pop_skid_buf
//
// Small circular buffer that absorbs words arriving from the FIFO read port.
// Words are written at the tail on push and presented at the head; pop
// advances the head. Push and pop in the same cycle keep the occupancy
// unchanged and preserve ordering.
//
// Ports:
//   clk        in   clock, rising edge
//   reset_L    in   asynchronous active-low reset (pointers and occupancy)
//   push       in   write push_data at the tail this edge
//   push_data  in   BW-bit word to store
//   pop        in   release the head word this edge
//   head       out  word at the head; 0 while empty
//   occ        out  number of stored words, 0..SKID_DEPTH
// -----------------------------------------------------------------------------
module pop_skid_buf
    import fifo_pop_pkg::*;
#(
    parameter  int BW         = 4,
    parameter  int SKID_DEPTH = SKID_DEPTH_DEF,
    localparam int OCC_W      = occ_width(SKID_DEPTH),
    localparam int PTR_W      = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             push,
    input  logic [BW-1:0]    push_data,
    input  logic             pop,
    output logic [BW-1:0]    head,
    output logic [OCC_W-1:0] occ
);

    logic [BW-1:0]    mem [SKID_DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [OCC_W-1:0] count;
    logic             full;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so non-power-of-two depths also work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(SKID_DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign full    = (count == OCC_W'(SKID_DEPTH));
    assign do_pop  = pop && (count != '0);
    // A push into a full buffer is only legal when the head leaves the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= ptr_inc(wptr);
            end
            if (do_pop) begin
                rptr <= ptr_inc(rptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + OCC_W'(1);
                2'b01:   count <= count - OCC_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; empty entries are masked at the head instead.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= push_data;
        end
    end

    assign head = (count != '0) ? mem[rptr] : '0;
    assign occ  = count;

endmodule

// File: rtl/fifo_pop_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_pop_ctrl
//
// Read-side controller for the dual-port-memory FIFO. Issues read strobes to
// the FIFO, catches the words one cycle later in a skid buffer, and hands
// them to a downstream consumer over a valid/ready stream at up to one word
// per cycle. An IDLE/RUN/FLUSH state machine lets the scheduler start and
// stop draining without losing or duplicating words. SKID_DEPTH must be >= 2.
//
// Ports:
//   clk                in   clock, rising edge
//   reset_L            in   asynchronous active-low reset
//   enable             in   1 = drain FIFO; falling edge starts a flush
//   fifo_empty         in   FIFO empty flag
//   fifo_almost_empty  in   FIFO almost-empty flag (status only)
//   fifo_data_out      in   FIFO read data, valid the cycle after fifo_rd
//   fifo_rd            out  read strobe to the FIFO (combinational)
//   stream             if   master side of the downstream valid/ready stream
//   busy               out  state != IDLE
//   low_water          out  registered almost-empty, gated by RUN
//   word_count         out  words accepted downstream, wraps mod 2^CNT_W
// -----------------------------------------------------------------------------
module fifo_pop_ctrl
    import fifo_pop_pkg::*;
#(
    parameter  int BW         = 4,
    parameter  int SKID_DEPTH = SKID_DEPTH_DEF,
    parameter  int CNT_W      = 8,
    localparam int OCC_W      = occ_width(SKID_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic                  fifo_almost_empty,
    input  logic [BW-1:0]         fifo_data_out,
    output logic                  fifo_rd,
    fifo_pop_ctrl_if.master       stream,
    output logic                  busy,
    output logic                  low_water,
    output logic [CNT_W-1:0]      word_count
);

    state_t           state;
    logic             pend;
    logic             pop;
    logic [OCC_W-1:0] occ;
    logic [BW-1:0]    head;
    int               fill_next;
    logic             drained;

    pop_skid_buf #(
        .BW         (BW),
        .SKID_DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk       (clk),
        .reset_L   (reset_L),
        .push      (pend),
        .push_data (fifo_data_out),
        .pop       (pop),
        .head      (head),
        .occ       (occ)
    );

    assign stream.out_valid = (occ != '0);
    assign stream.out_data  = head;
    assign pop              = stream.out_valid && stream.out_ready;

    // Occupancy after this edge: buffered words plus the word landing now,
    // minus the word leaving now. A new read is allowed only if its word
    // will have a free slot when it arrives next cycle.
    always_comb begin
        fill_next = int'(occ) + int'(pend) - int'(pop);
    end

    // state is async-reset to IDLE, so fifo_rd is low throughout reset.
    assign fifo_rd = (state == RUN) && !fifo_empty && (fill_next < SKID_DEPTH);

    // Nothing buffered or in flight once this edge retires; leaving FLUSH on
    // this condition drops busy the cycle after the last pop.
    assign drained = (fill_next == 0);

    // Enable/flush state machine with registered status outputs.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state     <= IDLE;
            busy      <= 1'b0;
            low_water <= 1'b0;
        end else begin
            low_water <= fifo_almost_empty && (state == RUN);
            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (enable) begin
                        state <= RUN;
                    end else if (drained) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Read-latency tracker: a strobe this cycle means a word lands next cycle.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            pend <= 1'b0;
        end else begin
            pend <= fifo_rd;
        end
    end

    // Delivered-word counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            word_count <= '0;
        end else if (pop) begin
            word_count <= word_count + CNT_W'(1);
        end
    end

endmodule

// File: doc/fifo_pop_ctrl.md
# fifo_pop_ctrl

Read-side controller for the dual-port-memory FIFO. It drains words from the FIFO's read port and absorbs the FIFO's one-cycle read latency in a small skid buffer. It presents the words to a downstream consumer over a valid/ready handshake, with sustained throughput of one word per cycle. An enable/flush state machine lets the upstream scheduler start and stop draining cleanly, without losing or duplicating words.

## Interface
- BW, 4, data width; equals FIFO width.
- SKID_DEPTH, 2, skid buffer entries; minimum 2.
- CNT_W, 8, width of delivered-word counter.

Ports:
- clk  in  1  single clock, rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- enable  in  1  1 = drain FIFO; 1→0 starts a flush.
- fifo_empty  in  1  FIFO empty flag.
- fifo_almost_empty  in  1  FIFO almost-empty flag; status only.
- fifo_data_out  in  BW  FIFO read data; valid the cycle after fifo_rd.
- fifo_rd  out  1  read strobe to the FIFO.
- out_valid  out  1  out_data holds a word.
- out_ready  in  1  consumer accepts when high together with out_valid.
- out_data  out  BW  head of the skid buffer.
- busy  out  1  state != IDLE.
- low_water  out  1  registered copy of fifo_almost_empty, gated by state == RUN.
- word_count  out  CNT_W  words accepted downstream; wraps modulo 2^CNT_W.

## Operation
States:
- IDLE: no reads issued.
  - enable=1 → RUN.
- RUN: reads are issued per the rule below.
  - enable=0 → FLUSH.
- FLUSH: no new reads. Pending reads still land, and buffered words are still delivered.
  - When pend=0 and occ=0 → IDLE.
  - If enable=1 returns during FLUSH → RUN directly.

Internal state:
- occ: number of buffered words, 0..SKID_DEPTH.
- pend: 1 if a word is arriving this cycle (fifo_rd was high in the previous cycle), else 0.

Read rule (combinational):
- fifo_rd = (state==RUN) && !fifo_empty && (occ + pend − pop < SKID_DEPTH).
- pop = out_valid && out_ready.

Data handling:
- In the cycle after fifo_rd=1, fifo_data_out is written to the buffer tail at the clock edge.
- out_data is always the buffer head. out_valid = (occ != 0).
- Push and pop in the same cycle: occ is unchanged and ordering is preserved.
- Once out_valid is high, out_data must stay stable until accepted. It is never withdrawn, including during FLUSH.
- word_count increments on every pop. 2^CNT_W − 1 wraps to 0.
- fifo_almost_empty is only sampled; it never affects control.

Reset (asynchronous):
- State goes to IDLE; occ, pend, word_count, low_water, busy, out_valid = 0; out_data = 0; fifo_rd = 0.
- Reset mid-operation discards buffered and in-flight words.
- fifo_rd must be 0 while reset_L=0.

## Timing
- enable rises in cycle T: state=RUN from T+1, so the first possible fifo_rd is in T+1.
- fifo_rd in cycle T: data is captured at the end of T+1, and out_valid is high in T+2. Read-to-valid latency is 2 cycles.
- Steady state with out_ready=1 and the FIFO non-empty: fifo_rd=1 every cycle and one word per cycle out.
- out_ready=0 with the buffer full (occ=2) or full-pending (occ=1, pend=1): fifo_rd=0 from that cycle on. No overflow is possible.
- fifo_empty=1: fifo_rd=0 in the same cycle, since fifo_rd is combinational from fifo_empty. The FIFO never sees a read while empty.
- enable falls in T: state=FLUSH from T+1. The last fifo_rd can occur in T. IDLE follows the cycle after the last pop.

## Structure
- Shared package `fifo_pop_pkg`:
  - state encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_FLUSH=2'd2.
  - default SKID_DEPTH.
- Sub-module `pop_skid_buf`:
  - parameterized BW × SKID_DEPTH circular buffer.
  - push/pop/occ, wptr/rptr wrap.
  - output head.
- The top level holds the FSM, pend flag, read rule and counter.
- Synthesizes alongside the existing FIFO and is checked behavioural-vs-structural against the same probe.

## Test plan
- Reset mid-stream: reset_L=0 with occ=2 → fifo_rd, out_valid, busy, word_count are all 0 immediately; after release, nothing is delivered until enable=1.
- Streaming: FIFO preloaded with 1,2,3,4; enable=1 and out_ready=1 → fifo_rd high for 4 consecutive cycles; out_data = 1,2,3,4 on consecutive cycles starting 2 cycles after the first read; word_count=4.
- Backpressure: out_ready=0 after the first word appears → at most 2 words buffered; fifo_rd stays 0; out_data holds 1; releasing out_ready delivers 1,2,3,4 in order, with no duplicates.
- Empty boundary: FIFO holds 1 word → exactly one fifo_rd pulse; fifo_rd is never high while fifo_empty=1.
- Flush: drop enable while occ=1 and pend=1 → both words are delivered; busy falls the cycle after the second pop; the FIFO retains its remaining words.
- Counter wrap: CNT_W=2, 5 words delivered → word_count reads 1.
